// File: rtl/pipelined_cpu.sv
// Four-stage (IF/ID/EX/WB) 16-bit CPU with internal program ROM, 16x16 register file
// and start/stop run control. Registers are exported on seg0..segf, the PC on led.
module pipelined_cpu (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic        start,
   input  logic        stop,
   output logic [7:0]  led,
   output logic [15:0] seg0,
   output logic [15:0] seg1,
   output logic [15:0] seg2,
   output logic [15:0] seg3,
   output logic [15:0] seg4,
   output logic [15:0] seg5,
   output logic [15:0] seg6,
   output logic [15:0] seg7,
   output logic [15:0] seg8,
   output logic [15:0] seg9,
   output logic [15:0] sega,
   output logic [15:0] segb,
   output logic [15:0] segc,
   output logic [15:0] segd,
   output logic [15:0] sege,
   output logic [15:0] segf
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_SL   = 4'h5;
   localparam logic [3:0] OP_SR   = 4'h6;
   localparam logic [3:0] OP_LDI  = 4'h7;
   localparam logic [3:0] OP_JMP  = 4'hB;
   localparam logic [3:0] OP_BNZ  = 4'hC;
   localparam logic [3:0] OP_HALT = 4'hF;

   function automatic logic [15:0] rom_read(input logic [7:0] addr);
      case (addr)
         8'd0:    rom_read = 16'h7101;
         8'd1:    rom_read = 16'h720A;
         8'd2:    rom_read = 16'h7300;
         8'd3:    rom_read = 16'h1332;
         8'd4:    rom_read = 16'h2221;
         8'd5:    rom_read = 16'hC203;
         8'd6:    rom_read = 16'hF000;
         default: rom_read = '0;
      endcase
   endfunction

   logic [0:0]  state_q, state_d;
   logic [7:0]  pc_q, pc_d;
   logic [15:0] ifid_ir_q, ifid_ir_d;
   logic [7:0]  ifid_pc_q, ifid_pc_d;
   logic [3:0]  idex_op_q, idex_op_d;
   logic [3:0]  idex_rd_q, idex_rd_d;
   logic [15:0] idex_a_q, idex_a_d;
   logic [15:0] idex_b_q, idex_b_d;
   logic [7:0]  idex_imm_q, idex_imm_d;
   logic [7:0]  idex_pc_q, idex_pc_d;
   logic        exwb_we_q, exwb_we_d;
   logic [3:0]  exwb_rd_q, exwb_rd_d;
   logic [15:0] exwb_res_q, exwb_res_d;
   logic [15:0] regs_q [16];
   logic [15:0] regs_d [16];

   logic [3:0]  id_op, id_rd, id_ra, id_rt;
   logic [15:0] id_a, id_b;
   logic [15:0] ex_res;
   logic        ex_we, ex_taken, ex_halt, advance;

   // EX result / EX-WB bypass ----------------------------------------------------
   always_comb begin
      ex_res = '0;
      ex_we  = 1'b1;
      case (idex_op_q)
         OP_ADD:  ex_res = idex_a_q + idex_b_q;
         OP_SUB:  ex_res = idex_a_q - idex_b_q;
         OP_AND:  ex_res = idex_a_q & idex_b_q;
         OP_OR:   ex_res = idex_a_q | idex_b_q;
         OP_SL:   ex_res = idex_a_q << idex_b_q[3:0];
         OP_SR:   ex_res = idex_a_q >> idex_b_q[3:0];
         OP_LDI:  ex_res = {8'h00, idex_imm_q};
         default: ex_we  = 1'b0;
      endcase
      ex_taken = (idex_op_q == OP_JMP) || ((idex_op_q == OP_BNZ) && (idex_a_q != '0));
      ex_halt  = (idex_op_q == OP_HALT);

      id_op = ifid_ir_q[15:12];
      id_rd = ifid_ir_q[11:8];
      id_rt = ifid_ir_q[3:0];
      // BNZ tests rd, so rd is routed through the first operand port
      id_ra = (id_op == OP_BNZ) ? id_rd : ifid_ir_q[7:4];

      if (ex_we && (idex_rd_q == id_ra))
         id_a = ex_res;
      else if (exwb_we_q && (exwb_rd_q == id_ra))
         id_a = exwb_res_q;
      else
         id_a = regs_q[id_ra];

      if (ex_we && (idex_rd_q == id_rt))
         id_b = ex_res;
      else if (exwb_we_q && (exwb_rd_q == id_rt))
         id_b = exwb_res_q;
      else
         id_b = regs_q[id_rt];
   end

   // Pipeline advance, flush and run control -------------------------------------
   always_comb begin
      advance    = (state_q == ST_RUN) && !stop;
      state_d    = state_q;
      pc_d       = pc_q;
      ifid_ir_d  = ifid_ir_q;
      ifid_pc_d  = ifid_pc_q;
      idex_op_d  = idex_op_q;
      idex_rd_d  = idex_rd_q;
      idex_a_d   = idex_a_q;
      idex_b_d   = idex_b_q;
      idex_imm_d = idex_imm_q;
      idex_pc_d  = idex_pc_q;
      exwb_we_d  = 1'b0;
      exwb_rd_d  = exwb_rd_q;
      exwb_res_d = exwb_res_q;
      regs_d     = regs_q;

      if (exwb_we_q)
         regs_d[exwb_rd_q] = exwb_res_q;

      if ((state_q == ST_RUN) && stop)
         state_d = ST_IDLE;
      else if ((state_q == ST_IDLE) && start && !stop)
         state_d = ST_RUN;

      if (advance) begin
         exwb_we_d  = ex_we;
         exwb_rd_d  = idex_rd_q;
         exwb_res_d = ex_res;
         if (ex_halt || ex_taken) begin
            pc_d       = ex_halt ? idex_pc_q : idex_imm_q;
            state_d    = ex_halt ? ST_IDLE : state_q;
            ifid_ir_d  = '0;
            ifid_pc_d  = '0;
            idex_op_d  = OP_NOP;
            idex_rd_d  = '0;
            idex_a_d   = '0;
            idex_b_d   = '0;
            idex_imm_d = '0;
            idex_pc_d  = '0;
         end else begin
            pc_d       = pc_q + 8'd1;
            ifid_ir_d  = rom_read(pc_q);
            ifid_pc_d  = pc_q;
            idex_op_d  = id_op;
            idex_rd_d  = id_rd;
            idex_a_d   = id_a;
            idex_b_d   = id_b;
            idex_imm_d = ifid_ir_q[7:0];
            idex_pc_d  = ifid_pc_q;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RSTN) begin
         state_q    <= ST_IDLE;
         pc_q       <= '0;
         ifid_ir_q  <= '0;
         ifid_pc_q  <= '0;
         idex_op_q  <= OP_NOP;
         idex_rd_q  <= '0;
         idex_a_q   <= '0;
         idex_b_q   <= '0;
         idex_imm_q <= '0;
         idex_pc_q  <= '0;
         exwb_we_q  <= 1'b0;
         exwb_rd_q  <= '0;
         exwb_res_q <= '0;
         for (int unsigned i = 0; i < 16; i++)
            regs_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ifid_ir_q  <= ifid_ir_d;
         ifid_pc_q  <= ifid_pc_d;
         idex_op_q  <= idex_op_d;
         idex_rd_q  <= idex_rd_d;
         idex_a_q   <= idex_a_d;
         idex_b_q   <= idex_b_d;
         idex_imm_q <= idex_imm_d;
         idex_pc_q  <= idex_pc_d;
         exwb_we_q  <= exwb_we_d;
         exwb_rd_q  <= exwb_rd_d;
         exwb_res_q <= exwb_res_d;
         for (int unsigned i = 0; i < 16; i++)
            regs_q[i] <= regs_d[i];
      end
   end

   assign led  = pc_q;
   assign seg0 = regs_q[0];
   assign seg1 = regs_q[1];
   assign seg2 = regs_q[2];
   assign seg3 = regs_q[3];
   assign seg4 = regs_q[4];
   assign seg5 = regs_q[5];
   assign seg6 = regs_q[6];
   assign seg7 = regs_q[7];
   assign seg8 = regs_q[8];
   assign seg9 = regs_q[9];
   assign sega = regs_q[10];
   assign segb = regs_q[11];
   assign segc = regs_q[12];
   assign segd = regs_q[13];
   assign sege = regs_q[14];
   assign segf = regs_q[15];

endmodule

// File: tb/tb_pipelined_cpu.sv
// Scoreboard bench for pipelined_cpu: expected register/PC snapshots come from an
// ISA-level reference model or hand-traced pipeline timing, compared at negedges.
module tb_pipelined_cpu;

   logic        CLK = 1'b0;
   logic        RSTN, start, stop;
   logic [7:0]  led;
   logic [15:0] seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
   logic [15:0] seg8, seg9, sega, segb, segc, segd, sege, segf;

   pipelined_cpu dut (
      .CLK(CLK), .RSTN(RSTN), .start(start), .stop(stop), .led(led),
      .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
      .seg4(seg4), .seg5(seg5), .seg6(seg6), .seg7(seg7),
      .seg8(seg8), .seg9(seg9), .sega(sega), .segb(segb),
      .segc(segc), .segd(segd), .sege(sege), .segf(segf)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string       tag;
      int unsigned sel;
      logic [15:0] val;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   logic [15:0] e_regs [16];
   logic [7:0]  e_pc;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [15:0] obs(input int unsigned sel);
      case (sel)
         0: obs = seg0;   1: obs = seg1;   2: obs = seg2;   3: obs = seg3;
         4: obs = seg4;   5: obs = seg5;   6: obs = seg6;   7: obs = seg7;
         8: obs = seg8;   9: obs = seg9;  10: obs = sega;  11: obs = segb;
        12: obs = segc;  13: obs = segd;  14: obs = sege;  15: obs = segf;
         default: obs = {8'h00, led};
      endcase
   endfunction

   task automatic push_exp(input string tag, input int unsigned sel, input logic [15:0] v);
      exp_t e;
      e.tag = tag; e.sel = sel; e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic push_state(input string tag);
      for (int i = 0; i < 16; i++)
         push_exp($sformatf("%s_seg%0d", tag, i), i, e_regs[i]);
      push_exp($sformatf("%s_led", tag), 16, {8'h00, e_pc});
   endtask

   task automatic drain();
      exp_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_eq(e.tag, obs(e.sel), e.val);
      end
   endtask

   task automatic set_zero();
      for (int i = 0; i < 16; i++) e_regs[i] = '0;
      e_pc = '0;
   endtask

   function automatic logic [15:0] prog(input logic [7:0] a);
      case (a)
         8'd0: prog = 16'h7101;  8'd1: prog = 16'h720A;  8'd2: prog = 16'h7300;
         8'd3: prog = 16'h1332;  8'd4: prog = 16'h2221;  8'd5: prog = 16'hC203;
         8'd6: prog = 16'hF000;  default: prog = 16'h0000;
      endcase
   endfunction

   // Sequential ISA model: final architectural state after HALT
   task automatic run_model();
      logic [15:0] ir, a, b;
      logic [3:0]  op;
      set_zero();
      for (int step = 0; step < 2000; step++) begin
         ir = prog(e_pc);
         op = ir[15:12];
         a  = e_regs[ir[7:4]];
         b  = e_regs[ir[3:0]];
         if (op == 4'hF) break;
         e_pc = e_pc + 8'd1;
         case (op)
            4'h1: e_regs[ir[11:8]] = a + b;
            4'h2: e_regs[ir[11:8]] = a - b;
            4'h3: e_regs[ir[11:8]] = a & b;
            4'h4: e_regs[ir[11:8]] = a | b;
            4'h5: e_regs[ir[11:8]] = a << b[3:0];
            4'h6: e_regs[ir[11:8]] = a >> b[3:0];
            4'h7: e_regs[ir[11:8]] = {8'h00, ir[7:0]};
            4'hB: e_pc = ir[7:0];
            4'hC: if (e_regs[ir[11:8]] != 16'h0) e_pc = ir[7:0];
            default: ;
         endcase
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
   endtask

   task automatic do_reset();
      RSTN = 1'b1;
      @(negedge CLK);
      RSTN = 1'b0;
   endtask

   initial begin
      RSTN = 1'b1; start = 1'b1; stop = 1'b0;
      repeat (3) @(negedge CLK);
      RSTN = 1'b0; start = 1'b0;
      repeat (5) @(negedge CLK);
      set_zero();
      push_state("rst");
      drain();

      // start sampled at E0; now just past E0
      pulse_start();
      @(negedge CLK);
      push_exp("lat_led_e1", 16, 16'd1);
      drain();
      @(negedge CLK);
      push_exp("lat_led_e2", 16, 16'd2);
      drain();
      @(negedge CLK);
      push_exp("lat_led_e3", 16, 16'd3);
      push_exp("lat_seg1_e3", 1, 16'h0000);
      drain();
      @(negedge CLK);
      push_exp("lat_seg1_e4", 1, 16'h0001);
      drain();

      repeat (100) @(negedge CLK);
      run_model();
      push_state("run");
      drain();

      start = 1'b1; stop = 1'b1;
      @(negedge CLK);
      start = 1'b0; stop = 1'b0;
      repeat (10) @(negedge CLK);
      push_state("both");
      drain();

      pulse_start();
      repeat (20) @(negedge CLK);
      push_state("rehalt");
      drain();

      // Stop sampled at E10: taken BNZ at E8 set PC=3, ADD fetched at E9 -> PC 4,
      // with r1=1, r2=9 and r3=10 written back.
      do_reset();
      pulse_start();
      repeat (9) @(negedge CLK);
      stop = 1'b1;
      @(negedge CLK);
      stop = 1'b0;
      set_zero();
      e_regs[1] = 16'd1; e_regs[2] = 16'd9; e_regs[3] = 16'd10; e_pc = 8'd4;
      push_state("stop");
      drain();
      repeat (25) @(negedge CLK);
      push_state("frozen");
      drain();
      pulse_start();
      repeat (100) @(negedge CLK);
      run_model();
      push_state("resume");
      drain();

      do_reset();
      pulse_start();
      repeat (15) @(negedge CLK);
      RSTN = 1'b1;
      @(negedge CLK);
      set_zero();
      push_state("midrst");
      drain();
      RSTN = 1'b0;
      repeat (5) @(negedge CLK);
      push_state("postrst");
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipelined_cpu.md
# pipelined_cpu

Four-stage pipelined 16-bit CPU with an internal instruction ROM, a 16×16 register file and start/stop run control. It is the top-level compute block of the board design. The register file is exported on sixteen 16-bit display ports, and the program counter is exported on the LEDs.

## Interface
- No parameters.
- CLK  input  1  system clock; all state updates on rising edge.
- RSTN  input  1  synchronous, active-high reset (sampled on rising CLK).
- start  input  1  one-cycle pulse; begin or resume execution.
- stop  input  1  one-cycle pulse; pause execution.
- led  output  8  current PC (fetch address).
- seg0 … segf  output  16 each  contents of registers r0 … r15, continuously driven from the register file.

## Operation
- **Instruction format** (16 bits): op[15:12], rd[11:8], rs[7:4], rt[3:0]; imm8 = [7:0].
- **Opcodes:**
  - 0 NOP.
  - 1 ADD: rd = rs + rt.
  - 2 SUB: rd = rs − rt.
  - 3 AND: rd = rs & rt.
  - 4 OR: rd = rs | rt.
  - 5 SL: rd = rs << rt[3:0].
  - 6 SR (logical): rd = rs >> rt[3:0].
  - 7 LDI: rd = {8'h00, imm8}.
  - B JMP: PC = imm8.
  - C BNZ: if rd ≠ 0, PC = imm8.
  - F HALT.
  - All other opcodes execute as NOP.
- **Arithmetic** is 16-bit, modulo 2^16; no flags. r0 is an ordinary register.
- **Instruction ROM:** 256×16, combinational read at PC. Addresses 7–255 hold 0 (NOP). Default program:
  - 0: LDI r1,1 (7101)
  - 1: LDI r2,10 (720A)
  - 2: LDI r3,0 (7300)
  - 3: ADD r3,r3,r2 (1332)
  - 4: SUB r2,r2,r1 (2221)
  - 5: BNZ r2,3 (C203)
  - 6: HALT (F000)
- **Stages:** IF (fetch, PC+1) → ID (register read) → EX (ALU, branch resolve) → WB (register write).
- **Hazards, no stalls:**
  - The EX-stage result is forwarded into operands latched from ID.
  - A WB-stage write to the register being read in ID bypasses to the read data.
  - EX forwarding has priority over the WB bypass.
- **Branches/JMP** resolve in EX. When taken, PC is loaded with imm8 and the IF/ID and ID/EX contents become NOPs (2-cycle penalty). Not-taken branches cost nothing.
- **HALT reaching EX:**
  - Controller goes to IDLE.
  - Younger instructions are flushed.
  - PC is set to the HALT address.
  - Instructions older than the HALT complete normally (WB drains).
- **Run controller, two states:**
  - IDLE: PC and the IF/ID and ID/EX latches hold; EX/WB still drains.
  - RUN.
  - Transitions: IDLE→RUN on start. RUN→IDLE on stop or HALT.
  - start and stop asserted together: stop wins.
  - start while in RUN, or stop while in IDLE: no effect.
- **Resume after stop** continues at the held PC with pipeline contents intact.
- **Start after HALT** re-fetches the HALT, which stops the CPU again; r-state is unchanged.

## Timing
- **Reset (RSTN=1 at an edge):**
  - PC=0, all registers 0, all pipeline latches NOP, state IDLE.
  - led=0, seg0…segf=0.
  - Reset overrides start/stop and aborts any in-flight instruction.
- **Start latency:** start sampled high at edge E0 gives RUN after E0. Instruction 0 is fetched into IF/ID at E1, reaches ID/EX at E2 and EX/WB at E3, and its register write is visible on segN after E4.
- **Throughput:** one instruction per cycle, except 2 bubbles per taken branch/JMP.
- **Stop latency:** stop sampled at edge S leaves PC unchanged from S onward. The instruction already in EX/WB at S completes. Instructions in IF/ID and ID/EX hold until restart.
- **PC wrap-around:** PC increments modulo 256 (255→0).

## Test plan
- Reset with start pulsed during reset → after release, led=0, all segN=0, no execution.
- Reset, then one start pulse, run ≥80 cycles → seg1=0x0001, seg2=0x0000, seg3=0x0037 (55), led=6, state IDLE. Other segN stay 0.
- Start at E0 → seg1=0x0001 first visible after E4; led counts 1,2,3 on E1..E3.
- Start, then stop pulse 10 cycles later → led frozen for 20+ cycles and segN unchanged. Then start → final seg3=0x0037, identical to the uninterrupted run.
- start and stop asserted in the same cycle from IDLE → remains IDLE, led unchanged.
- After HALT, pulse start → led stays 6, registers unchanged. Assert RSTN mid-loop → all outputs 0 at next edge.
